switch_box: RTL and testbench

SWITCH_BOX -- requirements
Module: switch_box

---
 rtl/switch_box_pkg.sv | 25 ++
 rtl/switch_box_cfg_loader.sv | 126 ++++++++++++
 rtl/switch_box.sv | 80 ++++++++
 tb/tb_switch_box.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_box_pkg.sv
// ============================================================================
// Module      : switch_box_pkg
// Description : Shared types and helpers for the switch box routing block.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package switch_box_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int SEL_ZERO = 0;

  function automatic int sel_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_box_cfg_loader.sv
// ============================================================================
// Module      : switch_box_cfg_loader
// Description : Beat-serial config loader: shadow frame, parity, commit pulse.
//               Optional parity check enabled by SWITCH_BOX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module switch_box_cfg_loader
  import switch_box_pkg::*;
#(
  parameter int W     = 3,
  parameter int CFG_W = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_valid_i,
  input  logic [CFG_W-1:0]                  cfg_data_i,
`ifdef SWITCH_BOX_PARITY_EN
  input  logic                              cfg_par_i,
`endif
  output logic                              cfg_ready_o,
  output logic                              cfg_done_o,
  output logic                              cfg_err_o,
  output logic                              commit_o,
  output logic [2*W*sel_width(W)-1:0]       shadow_o
);

  localparam int SELW     = sel_width(W);
  localparam int CFG_BITS = 2 * W * SELW;
  localparam int BEATS    = (CFG_BITS + CFG_W - 1) / CFG_W;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_live;
  logic                r_done;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] w_hit;
  logic [CFG_BITS-1:0] w_data_rep;
  logic                w_accept;
  logic                w_last;
  logic                w_in_commit;
  logic                w_bad;

  // Each shadow bit knows which beat and which beat bit feed it.
  for (genvar j = 0; j < CFG_BITS; j++) begin : g_bit
    assign w_hit[j]      = (r_cnt == CNT_W'(j / CFG_W));
    assign w_data_rep[j] = cfg_data_i[j % CFG_W];
  end

  assign w_accept    = cfg_valid_i && cfg_ready_o;
  assign w_last      = (r_cnt == CNT_W'(BEATS - 1));
  assign w_in_commit = (r_state == ST_COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_LOAD: if (w_accept) w_state_nxt = w_last ? ST_COMMIT : ST_LOAD;
      ST_COMMIT:        w_state_nxt = ST_IDLE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = r_live && (r_state != ST_COMMIT);
    commit_o    = w_in_commit && !w_bad;
  end

  // Holds ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= commit_o;
      if (w_in_commit)   r_cnt <= '0;
      else if (w_accept) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_accept) r_shadow <= (r_shadow & ~w_hit) | (w_data_rep & w_hit);
    end
  end

`ifdef SWITCH_BOX_PARITY_EN
  logic r_bad;
  logic r_err;
  logic w_mismatch;

  assign w_mismatch = (cfg_par_i != ^cfg_data_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_in_commit && r_bad;
      if (w_in_commit)   r_bad <= 1'b0;
      else if (w_accept) r_bad <= r_bad | w_mismatch;
    end
  end

  assign w_bad     = r_bad;
  assign cfg_err_o = r_err;
`else
  assign w_bad     = 1'b0;
  assign cfg_err_o = 1'b0;
`endif

  assign cfg_done_o = r_done;
  assign shadow_o   = r_shadow;

endmodule

`default_nettype wire

// File: rtl/switch_box.sv
// ============================================================================
// Module      : switch_box
// Description : Configurable W-track switch box, west/north to east/south.
//               Optional config parity check enabled by SWITCH_BOX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module switch_box
  import switch_box_pkg::*;
#(
  parameter int W     = 3,
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     left_i,
  input  logic [W-1:0]     up_i,
  output logic [W-1:0]     right_o,
  output logic [W-1:0]     down_o,
  input  logic             route_en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CFG_W-1:0] cfg_data_i,
`ifdef SWITCH_BOX_PARITY_EN
  input  logic             cfg_par_i,
`endif
  output logic             cfg_done_o,
  output logic             cfg_err_o
);

  localparam int SELW     = sel_width(W);
  localparam int CFG_BITS = 2 * W * SELW;
  localparam int SRC_N    = 1 << SELW;

  logic [CFG_BITS-1:0] r_active;
  logic [CFG_BITS-1:0] w_shadow;
  logic                w_commit;
  logic [SRC_N-1:0]    w_src;
  logic [2*W-1:0]      w_route;

  switch_box_cfg_loader #(
    .W     (W),
    .CFG_W (CFG_W)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid_i),
    .cfg_data_i  (cfg_data_i),
`ifdef SWITCH_BOX_PARITY_EN
    .cfg_par_i   (cfg_par_i),
`endif
    .cfg_ready_o (cfg_ready_o),
    .cfg_done_o  (cfg_done_o),
    .cfg_err_o   (cfg_err_o),
    .commit_o    (w_commit),
    .shadow_o    (w_shadow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_active <= '0;
    else if (w_commit) r_active <= w_shadow;
  end

  // Source table indexed by select: 0, left tracks, up tracks, then zero padding.
  assign w_src = {{(SRC_N - 2*W - 1){1'b0}}, up_i, left_i, 1'b0};

  for (genvar k = 0; k < 2*W; k++) begin : g_out
    logic [SELW-1:0] w_sel;
    assign w_sel      = r_active[k*SELW +: SELW];
    assign w_route[k] = route_en_i && (w_sel != SELW'(SEL_ZERO)) && w_src[w_sel];
  end

  assign right_o = w_route[W-1:0];
  assign down_o  = w_route[2*W-1:W];

endmodule

`default_nettype wire

// File: tb/tb_switch_box.sv
// ============================================================================
// Module      : tb_switch_box
// Description : Directed bench for switch_box with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_switch_box;

  localparam int W     = 3;
  localparam int CFG_W = 8;
  localparam int SELW  = 3;
  localparam int BEATS = 3;
  localparam int FW    = BEATS * CFG_W;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             route_en  = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_par   = 1'b0;
  logic [W-1:0]     left_v    = '0;
  logic [W-1:0]     up_v      = '0;
  logic [CFG_W-1:0] cfg_data  = '0;
  logic [W-1:0]     right_w;
  logic [W-1:0]     down_w;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit ready_s  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  switch_box #(.W(W), .CFG_W(CFG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left_i      (left_v),
    .up_i        (up_v),
    .right_o     (right_w),
    .down_o      (down_w),
    .route_en_i  (route_en),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_data_i  (cfg_data),
`ifdef SWITCH_BOX_PARITY_EN
    .cfg_par_i   (cfg_par),
`endif
    .cfg_done_o  (cfg_done),
    .cfg_err_o   (cfg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frames as queues of beats ----------------
  int               m_active[2*W];
  logic [CFG_W-1:0] m_beats[$];
  bit m_live, m_commit, m_bad, m_done, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_active[k]) m_active[k] = 0;
      m_beats.delete();
      m_live = 0; m_commit = 0; m_bad = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_commit) begin
        if (m_bad) m_err = 1;
        else begin
          logic [FW-1:0] word;
          for (int b = 0; b < BEATS; b++) word[b*CFG_W +: CFG_W] = m_beats[b];
          for (int k = 0; k < 2*W; k++) m_active[k] = int'((word >> (k*SELW)) & FW'(7));
          m_done = 1;
        end
        m_beats.delete();
        m_commit = 0;
        m_bad    = 0;
      end else if (m_live && cfg_valid) begin
        m_beats.push_back(cfg_data);
`ifdef SWITCH_BOX_PARITY_EN
        if (cfg_par != ^cfg_data) m_bad = 1;
`endif
        if (m_beats.size() == BEATS) m_commit = 1;
      end
      m_live = 1;
    end
  end

  function automatic logic exp_bit(input int s, input logic [W-1:0] l, input logic [W-1:0] u);
    if (s >= 1 && s <= W)   return l[s-1];
    if (s > W && s <= 2*W)  return u[s-W-1];
    return 1'b0;
  endfunction

  always @(negedge clk) begin : p_cmp
    logic [W-1:0] er, ed;
    for (int k = 0; k < W; k++) begin
      er[k] = route_en && exp_bit(m_active[k],   left_v, up_v);
      ed[k] = route_en && exp_bit(m_active[k+W], left_v, up_v);
    end
    chk("right_o",     right_w,   er);
    chk("down_o",      down_w,    ed);
    chk("cfg_ready_o", cfg_ready, m_live && !m_commit);
    chk("cfg_done_o",  cfg_done,  m_done);
    chk("cfg_err_o",   cfg_err,   m_err);
    ready_s = cfg_ready;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [FW-1:0] pack(input int f[2*W]);
    logic [FW-1:0] w = '0;
    for (int k = 0; k < 2*W; k++) w = w | (FW'(f[k]) << (k*SELW));
    return w;
  endfunction

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [CFG_W-1:0] d, input bit flip);
    bit ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_par   = (^d) ^ flip;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge clk);
      ok = ready_s;
    end
    chk("beat_accept", ok, 1'b1);
    #2;
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input int f[2*W], input int gap, input int nbeats, input int bad_beat);
    logic [FW-1:0] w = pack(f);
    for (int b = 0; b < nbeats; b++) begin
      send_beat(w[b*CFG_W +: CFG_W], b == bad_beat);
      if (gap > 0 && b < nbeats - 1) idle(gap);
    end
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Field lists are indexed right_o[0]..right_o[2], down_o[0]..down_o[2].
  int fA[2*W] = '{1, 2, 3, 4, 5, 6};
  int fB[2*W] = '{4, 7, 0, 1, 2, 3};

  initial begin : p_stim
    logic [FW-1:0] wA;
    int c0;
    left_v = 3'b111;
    up_v   = 3'b111;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_right", right_w, 3'b000);
    chk("rst_down",  down_w,  3'b000);
    chk("rst_ready", cfg_ready, 1'b0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", cfg_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_edge", cfg_ready, 1'b1);

    // Frame A back-to-back: done two edges after the last beat
    sync();
    left_v = 3'b101;
    up_v   = 3'b010;
    send_frame(fA, 0, BEATS, -1);
    @(negedge clk);
    chk("A_commit_ready", cfg_ready, 1'b0);
    chk("A_commit_done",  cfg_done,  1'b0);
    chk("A_old_right",    right_w,   3'b000);
    @(negedge clk);
    chk("A_done",  cfg_done, 1'b1);
    chk("A_right", right_w,  3'b101);
    chk("A_down",  down_w,   3'b010);

    // Frame B with gaps, field 7 on right_o[1]
    sync();
    left_v = 3'b111;
    up_v   = 3'b111;
    @(negedge clk);
    chk("A_ones_right", right_w, 3'b111);
    sync();
    send_frame(fB, 2, BEATS, -1);
    @(negedge clk);
    chk("B_pre_right", right_w, 3'b111);
    @(negedge clk);
    chk("B_done",  cfg_done, 1'b1);
    chk("B_right", right_w,  3'b001);
    chk("B_down",  down_w,   3'b111);
    sync();
    route_en = 1'b0;
    @(negedge clk);
    chk("en_off_right", right_w, 3'b000);
    chk("en_off_down",  down_w,  3'b000);
    sync();
    route_en = 1'b1;

    // Frame A again with 2-cycle gaps
    left_v = 3'b101;
    up_v   = 3'b010;
    @(negedge clk);
    chk("B_mix_right", right_w, 3'b000);
    chk("B_mix_down",  down_w,  3'b101);
    sync();
    send_frame(fA, 2, BEATS, -1);
    @(negedge clk);
    @(negedge clk);
    chk("Agap_done",  cfg_done, 1'b1);
    chk("Agap_right", right_w,  3'b101);
    chk("Agap_down",  down_w,   3'b010);

    // Reset mid-frame, then a full frame
    sync();
    send_frame(fB, 0, 2, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_right", right_w, 3'b000);
    chk("mid_rst_ready", cfg_ready, 1'b0);
    sync();
    rst_n = 1'b1;
    sync();
    send_frame(fA, 0, BEATS, -1);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_done",  cfg_done, 1'b1);
    chk("post_rst_right", right_w,  3'b101);
    chk("post_rst_down",  down_w,   3'b010);

    // Back-to-back frames: next beat 0 is held through COMMIT
    sync();
    send_frame(fB, 0, BEATS, -1);
    c0 = cyc;
    wA = pack(fA);
    send_beat(wA[7:0], 1'b0);
    chk("b2b_beat0_edges", cyc - c0, 2);
    send_beat(wA[15:8], 1'b0);
    send_beat(wA[23:16], 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done",  cfg_done, 1'b1);
    chk("b2b_right", right_w,  3'b101);
    chk("b2b_down",  down_w,   3'b010);

`ifdef SWITCH_BOX_PARITY_EN
    // Wrong parity on beat 1: error pulse, routing kept
    sync();
    send_frame(fB, 0, BEATS, 1);
    @(negedge clk);
    chk("par_commit_err", cfg_err, 1'b0);
    @(negedge clk);
    chk("par_err",   cfg_err,  1'b1);
    chk("par_done",  cfg_done, 1'b0);
    chk("par_right", right_w,  3'b101);
    chk("par_down",  down_w,   3'b010);
    @(negedge clk);
    chk("par_err_pulse", cfg_err, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
